// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
package fir_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ISSUE   = 4'b0010,
    S_WAIT    = 4'b0100,
    S_DELIVER = 4'b1000
  } state_t;

  localparam int STATE_W = 4;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest-index requester at or after ptr, wrapping.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[CH_W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR MAC engine across NUM_CH sample streams with round-robin
// arbitration, tagged result delivery and an engine watchdog.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CH_W       = ch_width(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_din,
  input  logic [NUM_CH-1:0]            iv_ch_valid,
  output logic [NUM_CH-1:0]            ov_ch_ready,
  output logic [DATA_WIDTH-1:0]        ov_eng_din,
  output logic                         o_eng_din_valid,
  output logic [CH_W-1:0]              ov_eng_bank,
  input  logic                         i_eng_ready,
  input  logic [DATA_WIDTH-1:0]        iv_eng_dout,
  input  logic                         i_eng_dout_valid,
  output logic                         o_eng_ready,
  output logic [DATA_WIDTH-1:0]        ov_dout,
  output logic [CH_W-1:0]              ov_dout_ch,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready,
  output logic                         o_busy,
  output logic                         o_timeout_err,
  output logic [STATE_W-1:0]           ov_dbg_state
);

  // One extra bit so the count cannot wrap between an ack and the result.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CNT_W-1:0]  wd_cnt;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_req;
  logic [CH_W-1:0]   ptr_next;
  logic              wd_expired;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (iv_ch_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; valid, once raised by this block, holds with its data until then.
  assign ov_ch_ready  = (state == S_IDLE && i_en && !i_rst) ? grant : '0;
  assign ptr_next     = (ov_eng_bank == CH_W'(NUM_CH - 1)) ? '0 : ov_eng_bank + 1'b1;
  assign wd_expired   = (wd_cnt >= CNT_W'(TIMEOUT - 1));
  assign ov_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      ptr             <= '0;
      wd_cnt          <= '0;
      ov_eng_din      <= '0;
      o_eng_din_valid <= 1'b0;
      ov_eng_bank     <= '0;
      o_eng_ready     <= 1'b0;
      ov_dout         <= '0;
      ov_dout_ch      <= '0;
      o_dout_valid    <= 1'b0;
      o_busy          <= 1'b0;
      o_timeout_err   <= 1'b0;
    end else if (i_en) begin
      o_eng_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ov_eng_din      <= iv_ch_din[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            ov_eng_bank     <= grant_idx;
            o_eng_din_valid <= 1'b1;
            wd_cnt          <= '0;
            o_busy          <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A result arriving alongside the ack is left for WAIT to capture.
          if (i_eng_ready) begin
            o_eng_din_valid <= 1'b0;
            wd_cnt          <= wd_cnt + 1'b1;
            state           <= S_WAIT;
          end else if (wd_expired) begin
            o_timeout_err   <= 1'b1;
            o_eng_din_valid <= 1'b0;
            ptr             <= ptr_next;
            o_busy          <= 1'b0;
            state           <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_eng_dout_valid) begin
            ov_dout      <= iv_eng_dout;
            ov_dout_ch   <= ov_eng_bank;
            o_eng_ready  <= 1'b1;
            o_dout_valid <= 1'b1;
            state        <= S_DELIVER;
          end else if (wd_expired) begin
            o_timeout_err <= 1'b1;
            ptr           <= ptr_next;
            o_busy        <= 1'b0;
            state         <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (i_dout_ready) begin
            o_dout_valid <= 1'b0;
            ptr          <= ptr_next;
            o_busy       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: 4 channels, 24-bit data, watchdog of 16 cycles.
module tb_fir_channel_scheduler;
  import fir_sched_pkg::*;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TO  = 16;
  localparam logic [DW-1:0] MASK = 24'hA5A5A5;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_en;
  logic [NCH*DW-1:0] iv_ch_din;
  logic [NCH-1:0]    iv_ch_valid;
  logic [NCH-1:0]    ov_ch_ready;
  logic [DW-1:0]     ov_eng_din;
  logic              o_eng_din_valid;
  logic [CHW-1:0]    ov_eng_bank;
  logic              i_eng_ready;
  logic [DW-1:0]     iv_eng_dout;
  logic              i_eng_dout_valid;
  logic              o_eng_ready;
  logic [DW-1:0]     ov_dout;
  logic [CHW-1:0]    ov_dout_ch;
  logic              o_dout_valid;
  logic              i_dout_ready;
  logic              o_busy;
  logic              o_timeout_err;
  logic [3:0]        ov_dbg_state;

  logic          eng_echo;
  logic [DW-1:0] eng_dout_drv;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CHW-1:0] exp_q[$];

  // Instant-engine model: returns the issued sample XOR a fixed mask.
  assign iv_eng_dout = eng_echo ? (ov_eng_din ^ MASK) : eng_dout_drv;

  fir_channel_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_en             (i_en),
    .iv_ch_din        (iv_ch_din),
    .iv_ch_valid      (iv_ch_valid),
    .ov_ch_ready      (ov_ch_ready),
    .ov_eng_din       (ov_eng_din),
    .o_eng_din_valid  (o_eng_din_valid),
    .ov_eng_bank      (ov_eng_bank),
    .i_eng_ready      (i_eng_ready),
    .iv_eng_dout      (iv_eng_dout),
    .i_eng_dout_valid (i_eng_dout_valid),
    .o_eng_ready      (o_eng_ready),
    .ov_dout          (ov_dout),
    .ov_dout_ch       (ov_dout_ch),
    .o_dout_valid     (o_dout_valid),
    .i_dout_ready     (i_dout_ready),
    .o_busy           (o_busy),
    .o_timeout_err    (o_timeout_err),
    .ov_dbg_state     (ov_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] ch_sample(input int ch);
    return 24'h0A0000 | DW'(ch);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    iv_ch_valid = '1;
    tick();
    n_checks++;
    if (ov_ch_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", ov_ch_ready);
    end
    n_checks++;
    if ({ov_eng_din, o_eng_din_valid, ov_eng_bank, o_eng_ready, ov_dout, ov_dout_ch,
         o_dout_valid, o_busy, o_timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got din=%h dv=%b bank=%0d dout=%h busy=%b err=%b expected all 0",
                         ov_eng_din, o_eng_din_valid, ov_eng_bank, ov_dout, o_busy, o_timeout_err);
    end
    n_checks++;
    if (ov_dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", ov_dbg_state, S_IDLE);
    end
    iv_ch_valid = '0;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    iv_ch_din[2*DW +: DW] = 24'h000123;
    iv_ch_valid = 4'b0100;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b expected 0100", ov_ch_ready);
    end
    tick();
    n_checks++;
    if (o_eng_din_valid !== 1'b1 || ov_eng_din !== 24'h000123 || ov_eng_bank !== 2'd2 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_issue: got dv=%b din=%h bank=%0d busy=%b expected 1 000123 2 1",
                         o_eng_din_valid, ov_eng_din, ov_eng_bank, o_busy);
    end
    iv_ch_valid = '0;
    i_eng_ready = 1'b1;
    tick();
    i_eng_ready = 1'b0;
    n_checks++;
    if (o_eng_din_valid !== 1'b0 || ov_dbg_state !== S_WAIT) begin
      n_fail++; $display("FAIL single_wait: got dv=%b state=%b expected 0 %b", o_eng_din_valid, ov_dbg_state, S_WAIT);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_dout_valid !== 1'b0 || o_eng_ready !== 1'b0) begin
        n_fail++; $display("FAIL single_early: got dout_valid=%b eng_ready=%b expected 0 0", o_dout_valid, o_eng_ready);
      end
      tick();
    end
    eng_dout_drv = 24'h000456;
    i_eng_dout_valid = 1'b1;
    tick();
    i_eng_dout_valid = 1'b0;
    n_checks++;
    if (o_dout_valid !== 1'b1 || ov_dout !== 24'h000456 || ov_dout_ch !== 2'd2 || o_eng_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_result: got v=%b dout=%h ch=%0d eng_ready=%b expected 1 000456 2 1",
                         o_dout_valid, ov_dout, ov_dout_ch, o_eng_ready);
    end
    tick();
    n_checks++;
    if (o_eng_ready !== 1'b0 || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse: got eng_ready=%b dout_valid=%b expected 0 1", o_eng_ready, o_dout_valid);
    end
    i_dout_ready = 1'b1;
    tick();
    i_dout_ready = 1'b0;
    n_checks++;
    if (o_dout_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got dout_valid=%b busy=%b expected 0 0", o_dout_valid, o_busy);
    end
    iv_ch_din[2*DW +: DW] = ch_sample(2);
  endtask

  task automatic test_round_robin();
    int acc_cnt[NCH];
    int accepts = 0;
    int delivers = 0;
    logic [CHW-1:0] exp_acc[$];
    logic [CHW-1:0] ch;
    // Pointer sits at 3 after the single-channel transaction on ch2.
    exp_q = {2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    exp_acc = exp_q;
    foreach (acc_cnt[k]) acc_cnt[k] = 0;
    eng_echo = 1'b1;
    i_eng_ready = 1'b1;
    i_eng_dout_valid = 1'b1;
    i_dout_ready = 1'b1;
    iv_ch_valid = '1;
    #1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (ov_ch_ready !== '0) begin
        accepts++;
        for (int k = 0; k < NCH; k++) if (ov_ch_ready[k]) acc_cnt[k]++;
        if (exp_acc.size() > 0) begin
          ch = exp_acc.pop_front();
          n_checks++;
          if (ov_ch_ready !== (4'b0001 << ch)) begin
            n_fail++; $display("FAIL rr_grant: got %b expected channel %0d", ov_ch_ready, ch);
          end
        end
      end
      if (o_dout_valid === 1'b1) begin
        delivers++;
        if (exp_q.size() > 0) begin
          ch = exp_q.pop_front();
          n_checks++;
          if (ov_dout_ch !== ch || ov_dout !== (ch_sample(int'(ch)) ^ MASK)) begin
            n_fail++; $display("FAIL rr_result: got ch=%0d dout=%h expected ch=%0d dout=%h",
                               ov_dout_ch, ov_dout, ch, ch_sample(int'(ch)) ^ MASK);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (accepts != 8 || delivers != 8) begin
      n_fail++; $display("FAIL rr_throughput: got accepts=%0d delivers=%0d expected 8 8", accepts, delivers);
    end
    for (int k = 0; k < NCH; k++) begin
      n_checks++;
      if (acc_cnt[k] != 2) begin
        n_fail++; $display("FAIL rr_fairness: channel %0d got %0d accepts expected 2", k, acc_cnt[k]);
      end
    end
    iv_ch_valid = '0;
    eng_echo = 1'b0;
    i_eng_ready = 1'b0;
    i_eng_dout_valid = 1'b0;
    i_dout_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    eng_echo = 1'b1;
    i_eng_ready = 1'b1;
    i_eng_dout_valid = 1'b1;
    i_dout_ready = 1'b0;
    iv_ch_valid = 4'b0010;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_ready: got %b expected 0010", ov_ch_ready);
    end
    tick();
    iv_ch_valid = '1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_dout_valid !== 1'b1 || ov_dout !== (ch_sample(1) ^ MASK) || ov_dout_ch !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold: got v=%b dout=%h ch=%0d expected 1 %h 1",
                           o_dout_valid, ov_dout, ov_dout_ch, ch_sample(1) ^ MASK);
      end
      n_checks++;
      if (ov_ch_ready !== 4'b0000 || o_eng_din_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_idle: got ready=%b eng_din_valid=%b expected 0000 0", ov_ch_ready, o_eng_din_valid);
      end
      tick();
    end
    iv_ch_valid = '0;
    i_dout_ready = 1'b1;
    tick();
    n_checks++;
    if (o_dout_valid !== 1'b0 || ov_dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL bp_release: got v=%b state=%b expected 0 %b", o_dout_valid, ov_dbg_state, S_IDLE);
    end
    eng_echo = 1'b0;
    i_eng_ready = 1'b0;
    i_eng_dout_valid = 1'b0;
    i_dout_ready = 1'b0;
  endtask

  task automatic test_enable_freeze();
    iv_ch_valid = 4'b0001;
    i_en = 1'b0;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0000) begin
      n_fail++; $display("FAIL en_ready_gated: got %b expected 0000", ov_ch_ready);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || ov_dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL en_no_accept: got busy=%b state=%b expected 0 %b", o_busy, ov_dbg_state, S_IDLE);
    end
    i_en = 1'b1;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0001) begin
      n_fail++; $display("FAIL en_ready: got %b expected 0001", ov_ch_ready);
    end
    tick();
    iv_ch_valid = '0;
    for (int i = 0; i < 3; i++) tick();
    i_en = 1'b0;
    iv_ch_valid = '1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_eng_din_valid !== 1'b1 || ov_dbg_state !== S_ISSUE || ov_ch_ready !== 4'b0000) begin
        n_fail++; $display("FAIL en_frozen: got dv=%b state=%b ready=%b expected 1 %b 0000",
                           o_eng_din_valid, ov_dbg_state, ov_ch_ready, S_ISSUE);
      end
      tick();
    end
    iv_ch_valid = '0;
    i_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (o_eng_din_valid !== 1'b1 || o_timeout_err !== 1'b0) begin
        n_fail++; $display("FAIL en_counter: cycle %0d got dv=%b err=%b expected 1 0", i, o_eng_din_valid, o_timeout_err);
      end
      tick();
    end
    // Ack arrives on the cycle the watchdog would expire: the ack wins.
    i_eng_ready = 1'b1;
    tick();
    i_eng_ready = 1'b0;
    n_checks++;
    if (ov_dbg_state !== S_WAIT || o_timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL en_ack_wins: got state=%b err=%b expected %b 0", ov_dbg_state, o_timeout_err, S_WAIT);
    end
    eng_dout_drv = 24'h0BEEF0;
    i_eng_dout_valid = 1'b1;
    tick();
    i_eng_dout_valid = 1'b0;
    n_checks++;
    if (o_dout_valid !== 1'b1 || ov_dout !== 24'h0BEEF0 || ov_dout_ch !== 2'd0 || o_timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL en_complete: got v=%b dout=%h ch=%0d err=%b expected 1 0beef0 0 0",
                         o_dout_valid, ov_dout, ov_dout_ch, o_timeout_err);
    end
    i_dout_ready = 1'b1;
    tick();
    i_dout_ready = 1'b0;
  endtask

  task automatic test_timeout();
    iv_ch_valid = 4'b1100;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0100) begin
      n_fail++; $display("FAIL to_ready: got %b expected 0100", ov_ch_ready);
    end
    tick();
    for (int i = 0; i < TO; i++) begin
      n_checks++;
      if (o_eng_din_valid !== 1'b1 || o_timeout_err !== 1'b0) begin
        n_fail++; $display("FAIL to_waiting: cycle %0d got dv=%b err=%b expected 1 0", i, o_eng_din_valid, o_timeout_err);
      end
      tick();
    end
    n_checks++;
    if (o_timeout_err !== 1'b1 || o_eng_din_valid !== 1'b0 || o_busy !== 1'b0 ||
        o_dout_valid !== 1'b0 || ov_dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL to_expired: got err=%b dv=%b busy=%b dout_v=%b state=%b expected 1 0 0 0 %b",
                         o_timeout_err, o_eng_din_valid, o_busy, o_dout_valid, ov_dbg_state, S_IDLE);
    end
    n_checks++;
    if (ov_ch_ready !== 4'b1000) begin
      n_fail++; $display("FAIL to_next_grant: got %b expected 1000", ov_ch_ready);
    end
    iv_ch_valid = '0;
  endtask

  task automatic test_reset_mid();
    iv_ch_valid = 4'b0010;
    tick();
    iv_ch_valid = '0;
    i_eng_ready = 1'b1;
    tick();
    i_eng_ready = 1'b0;
    n_checks++;
    if (ov_dbg_state !== S_WAIT || o_timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL rm_setup: got state=%b err=%b expected %b 1", ov_dbg_state, o_timeout_err, S_WAIT);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_checks++;
    if ({ov_eng_din, o_eng_din_valid, ov_eng_bank, o_eng_ready, ov_dout, ov_dout_ch,
         o_dout_valid, o_busy, o_timeout_err} !== '0 || ov_dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL rm_cleared: got din=%h dv=%b bank=%0d dout_v=%b busy=%b err=%b state=%b expected 0s IDLE",
                         ov_eng_din, o_eng_din_valid, ov_eng_bank, o_dout_valid, o_busy, o_timeout_err, ov_dbg_state);
    end
    iv_ch_valid = '1;
    #1;
    n_checks++;
    if (ov_ch_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rm_pointer: got %b expected 0001", ov_ch_ready);
    end
    iv_ch_valid = '0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_en = 1'b1;
    iv_ch_valid = '0;
    i_eng_ready = 1'b0;
    i_eng_dout_valid = 1'b0;
    i_dout_ready = 1'b0;
    eng_echo = 1'b0;
    eng_dout_drv = '0;
    for (int k = 0; k < NCH; k++) iv_ch_din[k*DW +: DW] = ch_sample(k);
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_freeze();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
